// File: rtl/bram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_if
// Valid/ready word stream leaving the BRAM read sequencer.
//   m_data  : stream word (driven by master)
//   m_valid : word present (driven by master)
//   m_ready : consumer can take the word this cycle (driven by slave)
// Modports: master (producer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface bram_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Walks the read port of a simple dual-port BRAM over the window
// [base, base+len) (modulo 2^ADDRW) and turns the RAM's one-cycle registered
// read into a valid/ready stream with full throughput when never stalled.
//
// Ports:
//   clk, rst_n      : single clock (also the RAM read clock), async active-low reset
//   start           : one-cycle command, sampled only when idle
//   base, len       : window start address and word count (0..DEPTH)
//   busy, done      : transfer in progress / one-cycle completion pulse
//   bram_addr       : RAM read address (registered read pointer)
//   bram_data       : RAM registered read data
//   loop            : only with BRAM_STREAM_LOOP_EN; restart at base after the
//                     last address instead of finishing
//   strm            : stream output (bram_stream_reader_if.master)
//
// Optional feature macro: BRAM_STREAM_LOOP_EN (undefined = no loop port,
// transfers always end after one pass).
// -----------------------------------------------------------------------------
module bram_stream_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDRW-1:0]     base,
  input  logic [ADDRW:0]       len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRW-1:0]     bram_addr,
  input  logic [WIDTH-1:0]     bram_data,
`ifdef BRAM_STREAM_LOOP_EN
  input  logic                 loop,
`endif
  bram_stream_reader_if.master strm
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDRW:0] REM_ONE = (ADDRW+1)'(1);

  state_t           state;
  logic [ADDRW-1:0] addr_p0;   // read pointer presented to the RAM
  logic [ADDRW-1:0] base_q;
  logic [ADDRW:0]   len_q;
  logic [ADDRW:0]   rem;       // addresses still to issue in this pass
  logic             vld_p1;    // a read was issued last edge: bram_data is valid now
  logic [1:0]       cnt_p2;    // output buffer occupancy, 0..2
  logic [WIDTH-1:0] buf0_p2;   // buffer head
  logic [WIDTH-1:0] buf1_p2;
  logic             busy_q;
  logic             done_q;

  logic             loop_now;
  logic             pop;
  logic             push;
  logic [1:0]       occ;
  logic             issue;

`ifdef BRAM_STREAM_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign pop   = (cnt_p2 != 2'd0) && strm.m_ready;
  assign push  = vld_p1;
  // Buffered plus in-flight words; keeping this below 2 (or freeing a slot by
  // popping in the same cycle) is what keeps the 2-entry buffer from overflowing.
  assign occ   = cnt_p2 + {1'b0, vld_p1};
  assign issue = (state == RUN) && ((occ < 2'd2) || pop);

  assign bram_addr    = addr_p0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign strm.m_data  = buf0_p2;
  assign strm.m_valid = (cnt_p2 != 2'd0);

  // ---- stage p0: control FSM and address issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_p0 <= '0;
      base_q  <= '0;
      len_q   <= '0;
      rem     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_p1 <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state   <= RUN;
              busy_q  <= 1'b1;
              addr_p0 <= base;
              base_q  <= base;
              len_q   <= len;
              rem     <= len;
            end else begin
              // Empty window: acknowledge immediately without going busy.
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (rem == REM_ONE) begin
              if (loop_now) begin
                // Reload on the same edge as the last issue so the next
                // pass follows without a bubble.
                addr_p0 <= base_q;
                rem     <= len_q;
              end else begin
                addr_p0 <= addr_p0 + ADDRW'(1);
                rem     <= '0;
                state   <= DRAIN;
              end
            end else begin
              addr_p0 <= addr_p0 + ADDRW'(1);
              rem     <= rem - REM_ONE;
            end
          end
        end
        DRAIN: begin
          // Finish on the edge that hands off the final buffered word.
          if (!vld_p1 && ((cnt_p2 == 2'd0) || ((cnt_p2 == 2'd1) && pop))) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p2: capture RAM data into the 2-entry output buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2  <= 2'd0;
      buf0_p2 <= '0;
      buf1_p2 <= '0;
    end else begin
      if (push && pop) begin
        if (cnt_p2 == 2'd2) begin
          buf0_p2 <= buf1_p2;
          buf1_p2 <= bram_data;
        end else begin
          buf0_p2 <= bram_data;
        end
      end else if (push) begin
        if (cnt_p2 == 2'd0) buf0_p2 <= bram_data;
        else                buf1_p2 <= bram_data;
        cnt_p2 <= cnt_p2 + 2'd1;
      end else if (pop) begin
        buf0_p2 <= buf1_p2;
        cnt_p2  <= cnt_p2 - 2'd1;
      end
    end
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Downstream read-side sequencer for the simple dual-port block RAM. It walks the BRAM read port over a programmed address window and turns the RAM's one-cycle registered read into a valid/ready word stream. It sits between the RAM's read port and any stalling consumer (pixel/serializer/output stage), and guarantees full throughput when the consumer never stalls. All logic is on one clock domain; the RAM read clock must be this block's clock.

## Interface
- `WIDTH`, default 8: data word width; must match the RAM.
- `DEPTH`, default 256: RAM depth.
- `ADDRW`, default `$clog2(DEPTH)`: localparam, address width.

- `clk`, input, 1: the only clock; also drives the RAM read port.
- `rst_n`, input, 1: reset, **asynchronous, active-low**.
- `start`, input, 1: single-cycle command; sampled only in IDLE.
- `base`, input, ADDRW: first read address; latched on `start`.
- `len`, input, ADDRW+1: word count, 0..DEPTH; latched on `start`.
- `busy`, output, 1: high from the accepted `start` until the last word is handshaken.
- `done`, output, 1: one-cycle pulse when a transfer completes.
- `bram_addr`, output, ADDRW: drives the RAM read-address input.
- `bram_data`, input, WIDTH: the RAM's registered read data.
- `m_data`, output, WIDTH: stream data.
- `m_valid`, output, 1: stream valid.
- `m_ready`, input, 1: consumer ready.
- `loop`, input, 1: present only with `BRAM_STREAM_LOOP_EN` (see Configuration).

## Operation
- **States.**
  - IDLE: `start`=1 and `len`≠0 → RUN.
  - RUN: the last address is issued → DRAIN.
  - DRAIN: the buffer is empty and no read is in flight → IDLE, with a `done` pulse.
- **Zero length.** `start` with `len`=0 stays in IDLE and pulses `done` in the next cycle. `busy` stays 0.
- **Start while busy.** `start` asserted while `busy` is ignored.
- **Address issue.**
  - `bram_addr` is the registered read pointer.
  - A cycle "issues" when in RUN and (buffer count + in-flight) < 2, or when the same cycle pops a word (`m_valid && m_ready`).
  - On an issue edge, the pointer increments and the in-flight flag sets.
- **Address wrap.** The pointer wraps modulo 2^ADDRW, so `base`+`len` may cross the top of the RAM.
- **Capture.** The in-flight flag at an edge means `bram_data` is valid; it is pushed into the 2-entry buffer at that edge.
- **Stream output.**
  - `m_data` is the buffer head.
  - `m_valid` = buffer not empty.
  - `m_data` must hold stable while `m_valid && !m_ready`.
- **Buffer sizing.** The buffer never overflows; the credit rule above guarantees this.
- **Word count.** Exactly `len` words are emitted, in address order.
- **Reset.** Asynchronous, at any time, including mid-transfer:
  - state returns to IDLE; buffer empties; in-flight flag clears;
  - `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `bram_addr`=0.

## Timing
- **Start edge.** `start` is sampled at edge E0. `busy`=1 and `bram_addr`=`base` from E0.
- **First word.** The RAM samples `base` at E1; data is pushed at E2; `m_valid`=1 after E2. Latency from start to first valid is 2 cycles.
- **Throughput.** With `m_ready` held at 1: one word per cycle, no bubbles.
- **Backpressure.** Issue stops within one cycle of `m_ready`=0. At most 2 words are buffered.
- **Recovery.** Full rate resumes one cycle after `m_ready` returns to 1.
- **Completion.**
  - `done` is registered; it is high in the cycle after the edge on which the final handshake occurs.
  - `busy` falls at that same edge.
  - A new `start` is accepted in the `done` cycle.

## Configuration
- **`BRAM_STREAM_LOOP_EN` defined:**
  - Adds the `loop` input.
  - If `loop`=1 when the last address of the window is issued, the pointer reloads `base` and issue continues seamlessly, with no gap.
  - No `done` pulse is given between passes, and `busy` stays 1.
  - With `loop`=0 at that point, the transfer ends normally.
- **Not defined:** no `loop` port; behaviour is identical to `loop`=0 at all times.

## Test plan
- **Full-rate read.** Preload RAM[i]=i. `base`=0x10, `len`=4, `m_ready`=1.
  - Expect 0x10, 0x11, 0x12, 0x13 on consecutive cycles, with first `m_valid` 2 cycles after `start`.
  - Expect `done` pulsed once.
- **Wrap.** `DEPTH`=256, `base`=0xFE, `len`=4.
  - Expect data from addresses 0xFE, 0xFF, 0x00, 0x01.
- **Random backpressure.** `len`=256 with random `m_ready` (50%).
  - Expect all 256 words in order, none lost or duplicated.
  - Expect `m_data` stable during every stall.
- **Zero length and ignored start.**
  - `len`=0 → `done` pulse next cycle, `busy` never 1.
  - A second `start` mid-transfer has no effect.
- **Reset mid-transfer.** Assert `rst_n`=0 after 3 of 8 words.
  - Expect all outputs 0 immediately.
  - A fresh `start` after release gives a clean transfer.
- **Loop (macro on).** `base`=0, `len`=3, `loop`=1 for 7 words, then 0.
  - Expect 0, 1, 2, 0, 1, 2, 0, 1, 2 with no bubbles.
  - Expect a single `done`.
